// File: rtl/fixed_float_converter.sv
// Registered, independent float32 <-> Q2.FRAC_BITS converters for the CORDIC datapath boundary.
// Each direction has one cycle of latency, and its output holds when its input valid is low.
module fixed_float_converter #(
  parameter int FRAC_BITS = 20
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [31:0]            fl_in,
  input  logic                   fl_in_valid,
  input  logic [FRAC_BITS+1:0]   f_in,
  input  logic                   f_in_valid,
  output logic [FRAC_BITS+1:0]   f_out,
  output logic                   f_out_valid,
  output logic [31:0]            fl_out,
  output logic                   fl_out_valid
);

  localparam int W = FRAC_BITS + 2;

  // The significand {1,m} has weight 2^(e-150). Shifting right by (150-FRAC_BITS-e)
  // puts 2^-FRAC_BITS at the LSB and truncates the bits below it.
  function automatic logic [W-1:0] float_to_fixed(input logic [31:0] fl);
    logic [7:0]  e;
    logic [23:0] sig;
    logic [W-1:0] mag;
    int sh;
    e   = fl[30:23];
    sig = {1'b1, fl[22:0]};
    mag = '0;
    sh  = 0;
    float_to_fixed = '0;
    if (e == 8'd0 || (e == 8'hFF && fl[22:0] != 23'd0)) begin
      float_to_fixed = '0;
    end else if (e >= 8'd128) begin
      float_to_fixed = fl[31] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      sh  = 150 - FRAC_BITS - int'(e);
      mag = W'(sig >> sh);
      float_to_fixed = fl[31] ? -mag : mag;
    end
  endfunction

  // The most negative code negates to itself, which reads correctly as the unsigned magnitude 2^(W-1).
  function automatic logic [31:0] fixed_to_float(input logic [W-1:0] f);
    logic [W-1:0]  mag;
    logic [W+22:0] aligned;
    int p;
    mag = f[W-1] ? -f : f;
    p = 0;
    for (int i = 0; i < W; i++) begin
      if (mag[i]) p = i;
    end
    aligned = {mag, 23'd0} >> p;
    if (f == '0) fixed_to_float = 32'd0;
    else fixed_to_float = {f[W-1], 8'(127 + p - FRAC_BITS), aligned[22:0]};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_out        <= '0;
      f_out_valid  <= 1'b0;
      fl_out       <= '0;
      fl_out_valid <= 1'b0;
    end else begin
      f_out_valid  <= fl_in_valid;
      fl_out_valid <= f_in_valid;
      if (fl_in_valid) f_out  <= float_to_fixed(fl_in);
      if (f_in_valid)  fl_out <= fixed_to_float(f_in);
    end
  end

endmodule

// File: tb/tb_fixed_float_converter.sv
// Self-checking bench for fixed_float_converter: directed tables, reset, random traffic and round trips,
// checked against a real-arithmetic reference model.
module tb_fixed_float_converter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] fl_in;
  logic        fl_in_valid;
  logic [21:0] f_in;
  logic        f_in_valid;
  logic [21:0] f_out;
  logic        f_out_valid;
  logic [31:0] fl_out;
  logic        fl_out_valid;

  int checks = 0;
  int errors = 0;

  logic [21:0] exp_f;
  logic [31:0] exp_fl;
  logic        exp_fv;
  logic        exp_flv;

  fixed_float_converter #(.FRAC_BITS(20)) dut (
    .clk(clk), .rst_n(rst_n),
    .fl_in(fl_in), .fl_in_valid(fl_in_valid),
    .f_in(f_in), .f_in_valid(f_in_valid),
    .f_out(f_out), .f_out_valid(f_out_valid),
    .fl_out(fl_out), .fl_out_valid(fl_out_valid)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] fl; logic [21:0] fx; } f2x_vec_t;
  typedef struct { logic [21:0] fx; logic [31:0] fl; } x2f_vec_t;

  // Reference: evaluate the float as a real number, scale, truncate toward zero, saturate.
  function automatic logic [21:0] ref_f2x(input logic [31:0] b);
    int  e;
    real v;
    int  q;
    e = int'(b[30:23]);
    if (e == 0) return 22'd0;
    if (e == 255) begin
      if (b[22:0] != 23'd0) return 22'd0;
      return b[31] ? 22'h200000 : 22'h1FFFFF;
    end
    v = (1.0 + real'(b[22:0]) / 8388608.0) * (2.0 ** (e - 127));
    if (v >= 2.0) return b[31] ? 22'h200000 : 22'h1FFFFF;
    q = $rtoi(v * 1048576.0);
    if (b[31]) q = -q;
    return q[21:0];
  endfunction

  // Reference: normalise the real magnitude into [1,2) by repeated halving/doubling.
  function automatic logic [31:0] ref_x2f(input logic [21:0] f);
    int  fi;
    real a;
    int  ex;
    int  mant;
    logic [7:0] eb;
    fi = {{10{f[21]}}, f};
    if (fi == 0) return 32'd0;
    a  = real'(fi < 0 ? -fi : fi) / 1048576.0;
    ex = 0;
    while (a >= 2.0) begin a = a / 2.0; ex++; end
    while (a < 1.0)  begin a = a * 2.0; ex--; end
    mant = $rtoi((a - 1.0) * 8388608.0);
    eb = 8'(127 + ex);
    return {(fi < 0), eb, mant[22:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Present one cycle of stimulus, then check every output one cycle later.
  task automatic cycle(input logic flv, input logic [31:0] fl, input logic fv, input logic [21:0] f);
    fl_in = fl; fl_in_valid = flv; f_in = f; f_in_valid = fv;
    if (flv) exp_f = ref_f2x(fl);
    if (fv)  exp_fl = ref_x2f(f);
    exp_fv = flv;
    exp_flv = fv;
    @(posedge clk); #1;
    chk("f_out", 32'(f_out), 32'(exp_f));
    chk("f_out_valid", 32'(f_out_valid), 32'(exp_fv));
    chk("fl_out", fl_out, exp_fl);
    chk("fl_out_valid", 32'(fl_out_valid), 32'(exp_flv));
  endtask

  function automatic logic [31:0] rand_float();
    if ($urandom_range(0, 3) == 0) return $urandom;
    return {1'($urandom), 8'($urandom_range(100, 131)), 23'($urandom)};
  endfunction

  initial begin
    f2x_vec_t f2x_tab[11];
    x2f_vec_t x2f_tab[6];
    logic [21:0] codes[$];
    logic [31:0] fl_mid;

    f2x_tab[0]  = '{32'h3F800000, 22'h100000};
    f2x_tab[1]  = '{32'hBF800000, 22'h300000};
    f2x_tab[2]  = '{32'h3F490FDB, 22'h0C90FD};
    f2x_tab[3]  = '{32'hBF490FDB, 22'h336F03};
    f2x_tab[4]  = '{32'h40400000, 22'h1FFFFF};
    f2x_tab[5]  = '{32'hC0000000, 22'h200000};
    f2x_tab[6]  = '{32'h7F800000, 22'h1FFFFF};
    f2x_tab[7]  = '{32'h7FC00000, 22'h000000};
    f2x_tab[8]  = '{32'h35000000, 22'h000000};
    f2x_tab[9]  = '{32'h00000001, 22'h000000};
    f2x_tab[10] = '{32'h80000000, 22'h000000};
    x2f_tab[0]  = '{22'h09B74E, 32'h3F1B74E0};
    x2f_tab[1]  = '{22'h100000, 32'h3F800000};
    x2f_tab[2]  = '{22'h200000, 32'hC0000000};
    x2f_tab[3]  = '{22'h000001, 32'h35800000};
    x2f_tab[4]  = '{22'h3FFFFF, 32'hB5800000};
    x2f_tab[5]  = '{22'h000000, 32'h00000000};

    // Reset held low while valid operands are applied.
    rst_n = 1'b0;
    fl_in = 32'h3F800000; fl_in_valid = 1'b1; f_in = 22'h100000; f_in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst f_out", 32'(f_out), 32'd0);
    chk("rst f_out_valid", 32'(f_out_valid), 32'd0);
    chk("rst fl_out", fl_out, 32'd0);
    chk("rst fl_out_valid", 32'(fl_out_valid), 32'd0);
    fl_in_valid = 1'b0; f_in_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    exp_f = '0; exp_fl = '0; exp_fv = 1'b0; exp_flv = 1'b0;

    for (int i = 0; i < 11; i++) begin
      cycle(1'b1, f2x_tab[i].fl, i < 6, (i < 6) ? x2f_tab[i].fx : 22'd0);
      chk("f2x table", 32'(f_out), 32'(f2x_tab[i].fx));
      $display("f2x 0x%08h -> 0x%06h", f2x_tab[i].fl, f_out);
      if (i < 6) begin
        chk("x2f table", fl_out, x2f_tab[i].fl);
        $display("x2f 0x%06h -> 0x%08h", x2f_tab[i].fx, fl_out);
      end
    end

    // Hold behaviour: idle cycles must keep the last results.
    cycle(1'b1, 32'hBF490FDB, 1'b1, 22'h09B74E);
    cycle(1'b0, 32'h3F800000, 1'b0, 22'h100000);
    cycle(1'b0, 32'h40400000, 1'b1, 22'h3FFFFF);
    cycle(1'b1, 32'h3F800000, 1'b0, 22'h000001);
    chk("hold fl_out", fl_out, 32'hB5800000);

    // Asynchronous reset in the middle of traffic discards everything.
    cycle(1'b1, 32'h3F490FDB, 1'b1, 22'h100000);
    fl_in_valid = 1'b1; f_in_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("async rst f_out", 32'(f_out), 32'd0);
    chk("async rst fl_out", fl_out, 32'd0);
    chk("async rst f_out_valid", 32'(f_out_valid), 32'd0);
    chk("async rst fl_out_valid", 32'(fl_out_valid), 32'd0);
    fl_in_valid = 1'b0; f_in_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    exp_f = '0; exp_fl = '0;
    cycle(1'b1, 32'hBF800000, 1'b1, 22'h200000);
    chk("post rst f_out", 32'(f_out), 32'h300000);
    chk("post rst fl_out", fl_out, 32'hC0000000);

    // Random concurrent traffic with random valid gaps.
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 2) != 0), rand_float(),
            1'($urandom_range(0, 2) != 0), 22'($urandom));
    end

    // Round trip: fixed -> float -> fixed must be the identity.
    codes = '{22'h000000, 22'h000001, 22'h1FFFFF, 22'h200000, 22'h3FFFFF, 22'h100000, 22'h200001};
    for (int i = 0; i < 1500; i++) codes.push_back(22'($urandom));
    foreach (codes[i]) begin
      cycle(1'b0, 32'd0, 1'b1, codes[i]);
      fl_mid = fl_out;
      cycle(1'b1, fl_mid, 1'b0, 22'd0);
      chk("roundtrip", 32'(f_out), 32'(codes[i]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
